// File: rtl/range_frame_source.sv
// Framed sample source: buffers preloaded samples, streams them as one go/finish frame
// per start request and captures the receiver's returned range. Optional RANGE_FRAME_SELF_CHECK_EN.
module range_frame_source #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         wr_en,
    output logic                         wr_drop,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    input  logic                         start,
    output logic                         start_err,
    output logic                         busy,
    output logic [WIDTH-1:0]             data_out,
    output logic                         go,
    output logic                         finish,
    input  logic [WIDTH-1:0]             range_in,
    input  logic                         error_in,
    output logic [WIDTH-1:0]             result,
    output logic                         result_valid,
    output logic                         result_error,
    output logic                         result_mismatch
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_P  = PW'(DEPTH-1);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d, rem_q, rem_d;
    logic             err_acc_q, err_acc_d;
    logic             wr_drop_q, wr_drop_d, start_err_q, start_err_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             result_valid_q, result_valid_d;
    logic             result_error_q, result_error_d;
    logic             push, launch, posting;
    logic [CW-1:0]    count_w;

    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        rem_d          = rem_q;
        err_acc_d      = err_acc_q;
        start_err_d    = 1'b0;
        result_d       = result_q;
        result_valid_d = 1'b0;
        result_error_d = result_error_q;
        launch         = 1'b0;
        posting        = 1'b0;
        go             = 1'b0;
        finish         = 1'b0;
        data_out       = '0;
        busy           = (state_q != S_IDLE);

        // Writes land only while idle; a same-cycle start sees the new sample.
        push      = wr_en && (state_q == S_IDLE) && (count_q < DEPTH_C);
        wr_drop_d = wr_en && !push;
        count_w   = count_q + CW'(push);
        count_d   = count_w;
        if (push)
            wr_ptr_d = (wr_ptr_q == LAST_P) ? '0 : wr_ptr_q + PW'(1);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (count_w >= CW'(2)) begin
                        launch    = 1'b1;
                        rem_d     = count_w;
                        err_acc_d = 1'b0;
                        state_d   = S_SEND;
                    end else begin
                        start_err_d = 1'b1;
                    end
                end
            end
            S_SEND: begin
                go        = 1'b1;
                finish    = (rem_q == CW'(1));
                data_out  = mem_q[rd_ptr_q];
                rd_ptr_d  = (rd_ptr_q == LAST_P) ? '0 : rd_ptr_q + PW'(1);
                count_d   = count_q - CW'(1);
                rem_d     = rem_q - CW'(1);
                err_acc_d = err_acc_q | error_in;
                if (rem_q == CW'(1))
                    state_d = S_WAIT;
            end
            S_WAIT: begin
                // Receiver registers its range one cycle after finish, so sample it here.
                posting        = 1'b1;
                result_d       = range_in;
                result_valid_d = 1'b1;
                result_error_d = err_acc_q | error_in;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push)
            mem_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            rem_q          <= '0;
            err_acc_q      <= 1'b0;
            wr_drop_q      <= 1'b0;
            start_err_q    <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            result_error_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            rem_q          <= rem_d;
            err_acc_q      <= err_acc_d;
            wr_drop_q      <= wr_drop_d;
            start_err_q    <= start_err_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            result_error_q <= result_error_d;
        end
    end

`ifdef RANGE_FRAME_SELF_CHECK_EN
    logic [WIDTH-1:0] min_q, min_d, max_q, max_d;
    logic             first_q, first_d, mismatch_q, mismatch_d;

    always_comb begin
        min_d      = min_q;
        max_d      = max_q;
        first_d    = first_q;
        mismatch_d = 1'b0;
        if (launch)
            first_d = 1'b1;
        if (state_q == S_SEND) begin
            first_d = 1'b0;
            if (first_q) begin
                min_d = data_out;
                max_d = data_out;
            end else begin
                if (data_out < min_q) min_d = data_out;
                if (data_out > max_q) max_d = data_out;
            end
        end
        if (posting)
            mismatch_d = (range_in != (max_q - min_q));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            min_q      <= '0;
            max_q      <= '0;
            first_q    <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            min_q      <= min_d;
            max_q      <= max_d;
            first_q    <= first_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign result_mismatch = mismatch_q;
`else
    assign result_mismatch = 1'b0;
`endif

    assign wr_drop      = wr_drop_q;
    assign start_err    = start_err_q;
    assign count        = count_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign result_error = result_error_q;
endmodule
